// File: rtl/sseg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digits, per-slot blanking, leading-zero blanking.
// Outputs are registered (one cycle after state decision); no backpressure, load is a fire-and-forget strobe.
module sseg_scan_ctrl #(
    parameter int NDIGITS      = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   data_in,
    input  logic [NDIGITS-1:0]     dot_in,
    input  logic [NDIGITS-1:0]     den_in,
    input  logic                   lz_en,
    output logic [3:0]             seg_value,
    output logic [1:0]             seg_enable,
    output logic                   seg_dot,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic                   frame_start
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIGITS);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   started, started_n;
    logic                   boundary;

    logic [4*NDIGITS-1:0]   shadow_data, active_data;
    logic [NDIGITS-1:0]     shadow_dot, active_dot;
    logic [NDIGITS-1:0]     shadow_den, active_den;
    logic                   pending;

    logic [NDIGITS-1:0]     sup;
    logic                   all_zero;
    logic [3:0]             value_n;
    logic [1:0]             enable_n;
    logic                   dot_n;
    logic [NDIGITS-1:0]     sel_n;

    // sup[i]: this digit and every more significant one are zero
    always_comb begin
        sup      = '0;
        all_zero = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (active_data[4*i +: 4] == 4'h0);
            sup[i]   = lz_en & all_zero;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        started_n = started;
        boundary  = 1'b0;
        if (!run) begin
            state_n   = BLANK;
            idx_n     = '0;
            cnt_n     = '0;
            started_n = 1'b0;
        end else if (!started) begin
            // first slot after reset or run rising opens a fresh frame
            started_n = 1'b1;
            state_n   = BLANK;
            idx_n     = '0;
            cnt_n     = '0;
            boundary  = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1))
                        state_n = SHOW;
                    cnt_n = cnt + 1'b1;
                end
                SHOW: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        if (idx == IW'(NDIGITS - 1)) begin
                            idx_n    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = BLANK;
            endcase
        end

        sel_n    = '0;
        value_n  = 4'h0;
        enable_n = 2'b00;
        dot_n    = 1'b0;
        if (state_n == SHOW) begin
            sel_n[idx_n] = 1'b1;
            value_n      = active_data[{idx_n, 2'b00} +: 4];
            dot_n        = active_dot[idx_n];
            enable_n     = {active_dot[idx_n], active_den[idx_n] & ~sup[idx_n]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            started     <= 1'b0;
            digit_sel   <= '0;
            seg_value   <= 4'h0;
            seg_enable  <= 2'b00;
            seg_dot     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            started     <= started_n;
            digit_sel   <= sel_n;
            seg_value   <= value_n;
            seg_enable  <= enable_n;
            seg_dot     <= dot_n;
            frame_start <= boundary;
        end
    end

    // a load landing on the boundary edge bypasses shadow straight into active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dot  <= '0;
            shadow_den  <= '0;
            active_data <= '0;
            active_dot  <= '0;
            active_den  <= '0;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                shadow_data <= data_in;
                shadow_dot  <= dot_in;
                shadow_den  <= den_in;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    active_data <= data_in;
                    active_dot  <= dot_in;
                    active_den  <= den_in;
                end else if (pending) begin
                    active_data <= shadow_data;
                    active_dot  <= shadow_dot;
                    active_den  <= shadow_den;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with NDIGITS=4, PRESCALE=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_sseg_scan_ctrl;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dot_in;
    logic [3:0]  den_in;
    logic        lz_en;
    logic [3:0]  seg_value;
    logic [1:0]  seg_enable;
    logic        seg_dot;
    logic [3:0]  digit_sel;
    logic        frame_start;

    int n_assert = 0;
    int n_fail   = 0;

    sseg_scan_ctrl #(.NDIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .load       (load),
        .data_in    (data_in),
        .dot_in     (dot_in),
        .den_in     (den_in),
        .lz_en      (lz_en),
        .seg_value  (seg_value),
        .seg_enable (seg_enable),
        .seg_dot    (seg_dot),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input string tag, input logic [3:0] sel, input logic [3:0] val,
                        input logic [1:0] en, input logic dot);
        chk({tag, "_sel"}, 32'(digit_sel), 32'(sel));
        chk({tag, "_val"}, 32'(seg_value), 32'(val));
        chk({tag, "_en"},  32'(seg_enable), 32'(en));
        chk({tag, "_dot"}, 32'(seg_dot), 32'(dot));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; load = 1'b0; lz_en = 1'b0;
        data_in = '0; dot_in = '0; den_in = '0;
        #22;
        rst_n = 1'b1;
        show("reset", 4'b0000, 4'h0, 2'b00, 1'b0);
        chk("reset_fs", 32'(frame_start), 32'd0);

        // first frame after reset commits 1234 directly (load on boundary edge)
        run = 1'b1; load = 1'b1; data_in = 16'h1234; den_in = 4'hF; dot_in = 4'h0;
        tick(); load = 1'b0;                                  // c0
        chk("f0_fs", 32'(frame_start), 32'd1);
        chk("f0_dark", 32'(digit_sel), 32'd0);
        adv(2); show("f0_s0", 4'b0001, 4'h4, 2'b01, 1'b0);    // c2
        adv(5); show("f0_s0_end", 4'b0001, 4'h4, 2'b01, 1'b0); // c7
        adv(1); show("f0_s1_blank", 4'b0000, 4'h0, 2'b00, 1'b0); // c8
        chk("f0_fs_low", 32'(frame_start), 32'd0);
        adv(2); show("f0_s1", 4'b0010, 4'h3, 2'b01, 1'b0);    // c10

        // mid-frame load waits for the next frame
        load = 1'b1; data_in = 16'hABCD;
        tick(); load = 1'b0;                                  // c11
        adv(7); show("f0_s2", 4'b0100, 4'h2, 2'b01, 1'b0);    // c18
        adv(8); show("f0_s3", 4'b1000, 4'h1, 2'b01, 1'b0);    // c26
        adv(6); chk("f1_fs", 32'(frame_start), 32'd1);        // c32
        adv(2); show("f1_s0", 4'b0001, 4'hD, 2'b01, 1'b0);    // c34
        adv(8); show("f1_s1", 4'b0010, 4'hC, 2'b01, 1'b0);    // c42
        adv(8); show("f1_s2", 4'b0100, 4'hB, 2'b01, 1'b0);    // c50
        adv(8); show("f1_s3", 4'b1000, 4'hA, 2'b01, 1'b0);    // c58

        // leading-zero suppression, dot survives suppression
        load = 1'b1; data_in = 16'h0045; dot_in = 4'b0100; lz_en = 1'b1;
        tick(); load = 1'b0;                                  // c59
        adv(5); chk("f2_fs", 32'(frame_start), 32'd1);        // c64
        adv(2); show("lz_s0", 4'b0001, 4'h5, 2'b01, 1'b0);    // c66
        adv(8); show("lz_s1", 4'b0010, 4'h4, 2'b01, 1'b0);    // c74
        adv(8); show("lz_s2", 4'b0100, 4'h0, 2'b10, 1'b1);    // c82
        adv(8); show("lz_s3", 4'b1000, 4'h0, 2'b00, 1'b0);    // c90

        load = 1'b1; data_in = 16'h0000; dot_in = 4'b0000;
        tick(); load = 1'b0;                                  // c91
        adv(5); chk("f3_fs", 32'(frame_start), 32'd1);        // c96
        adv(2); show("lz0_s0", 4'b0001, 4'h0, 2'b01, 1'b0);   // c98
        adv(8); show("lz0_s1", 4'b0010, 4'h0, 2'b00, 1'b0);   // c106
        adv(16); show("lz0_s3", 4'b1000, 4'h0, 2'b00, 1'b0);  // c122

        // load coincident with the frame boundary
        adv(5); load = 1'b1; data_in = 16'h5555;              // c127
        tick(); load = 1'b0;                                  // c128
        chk("f4_fs", 32'(frame_start), 32'd1);
        chk("f4_pending", 32'(dut.pending), 32'd0);
        adv(2); show("f4_s0", 4'b0001, 4'h5, 2'b01, 1'b0);    // c130
        adv(24); show("f4_s3", 4'b1000, 4'h5, 2'b01, 1'b0);   // c154
        adv(6); chk("f5_fs", 32'(frame_start), 32'd1);        // c160
        chk("f5_pending", 32'(dut.pending), 32'd0);
        adv(2); show("f5_s0", 4'b0001, 4'h5, 2'b01, 1'b0);    // c162
        adv(16); show("f5_s2", 4'b0100, 4'h5, 2'b01, 1'b0);   // c178

        // run drop mid-SHOW; load still lands in shadow
        run = 1'b0;
        tick();                                               // c179
        show("stop", 4'b0000, 4'h0, 2'b00, 1'b0);
        chk("stop_fs", 32'(frame_start), 32'd0);
        load = 1'b1; data_in = 16'h0987;
        tick(); load = 1'b0;                                  // c180
        chk("stop_pending", 32'(dut.pending), 32'd1);
        adv(3); show("stop_hold", 4'b0000, 4'h0, 2'b00, 1'b0); // c183
        run = 1'b1;
        tick();                                               // c184
        chk("restart_fs", 32'(frame_start), 32'd1);
        chk("restart_dark", 32'(digit_sel), 32'd0);
        adv(2); show("rs_s0", 4'b0001, 4'h7, 2'b01, 1'b0);    // c186
        adv(8); show("rs_s1", 4'b0010, 4'h8, 2'b01, 1'b0);    // c194

        // asynchronous reset mid-SHOW
        rst_n = 1'b0;
        #1;
        show("arst", 4'b0000, 4'h0, 2'b00, 1'b0);
        chk("arst_pending", 32'(dut.pending), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();                                               // R
        chk("post_fs", 32'(frame_start), 32'd1);
        adv(2); show("post_s0", 4'b0001, 4'h0, 2'b00, 1'b0);  // R+2
        load = 1'b1; data_in = 16'h0000; den_in = 4'hF; dot_in = 4'h0; lz_en = 1'b0;
        tick(); load = 1'b0;                                  // R+3
        adv(29); chk("post_f1_fs", 32'(frame_start), 32'd1);  // R+32
        adv(2); show("post_f1_s0", 4'b0001, 4'h0, 2'b01, 1'b0); // R+34
        adv(8); show("post_f1_s1", 4'b0010, 4'h0, 2'b01, 1'b0); // R+42

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
